// File: rtl/reorder_buffer.sv
// In-order retirement buffer: records up to two dispatched rows per cycle, out-of-order FU
// completions, and retires up to three completed rows per cycle in program order.
package reorder_buffer_pkg;
   typedef logic [31:0] word;
   typedef logic [5:0]  p_reg;

   typedef struct packed {
      logic       valid;
      logic       complete;
      logic [3:0] ROBNumber;
      p_reg       PRegAddrDst;
      p_reg       OldPRegAddrDst;
      word        data;
      logic       RegWrite;
      logic       MemWrite;
   } rob_row_struct;
endpackage

module reorder_buffer
   import reorder_buffer_pkg::*;
#(
   parameter int DEPTH    = 16,
   parameter int RETIRE_W = 3
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  rob_row_struct i_alloc_rows      [0:1],
   input  logic          i_fu_valid        [0:2],
   input  logic [3:0]    i_fu_rob          [0:2],
   input  word           i_fu_data         [0:2],
   output rob_row_struct o_retire_rows     [0:RETIRE_W-1],
   output logic          o_rf_we           [0:RETIRE_W-1],
   output p_reg          o_rf_addr         [0:RETIRE_W-1],
   output word           o_rf_data         [0:RETIRE_W-1],
   output logic          o_free_preg_valid [0:RETIRE_W-1],
   output p_reg          o_free_preg       [0:RETIRE_W-1],
   output logic          o_store_commit    [0:RETIRE_W-1],
   output logic          o_full,
   output logic          o_empty,
   output logic [4:0]    o_count,
   output logic          o_err
);

   localparam logic [5:0] DEPTH_L = 6'(DEPTH);

   typedef struct packed {
      logic valid;
      logic complete;
      p_reg dst;
      p_reg old;
      word  data;
      logic reg_write;
      logic mem_write;
   } entry_t;

   entry_t        ent       [DEPTH];
   entry_t        ent_n     [DEPTH];
   logic [3:0]    head, head_n, tail, tail_n;
   logic [4:0]    count, count_n;
   logic          err_n;
   rob_row_struct ret_row_n [0:RETIRE_W-1];
   logic          rf_we_n   [0:RETIRE_W-1];
   logic          free_v_n  [0:RETIRE_W-1];
   logic          store_n   [0:RETIRE_W-1];
   logic [1:0]    ret_cnt, acc;
   logic          stop, dup;
   logic [3:0]    r_idx, c_idx, t;

   // Payload bits that dispatch drives but allocation always overwrites.
   logic unused_alloc_bits;
   assign unused_alloc_bits = ^{i_alloc_rows[0].complete, i_alloc_rows[0].data,
                                i_alloc_rows[1].complete, i_alloc_rows[1].data};

   always_comb begin
      ent_n   = ent;
      err_n   = o_err;
      ret_cnt = '0;
      acc     = '0;
      stop    = 1'b0;
      dup     = 1'b0;
      r_idx   = '0;
      c_idx   = '0;
      t       = tail;

      // Retirement scans the registered state only; the first incomplete entry stops it.
      for (int n = 0; n < RETIRE_W; n++) begin
         r_idx        = head + 4'(n);
         ret_row_n[n] = '0;
         rf_we_n[n]   = 1'b0;
         free_v_n[n]  = 1'b0;
         store_n[n]   = 1'b0;
         if (!stop && (5'(n) < count) && ent[r_idx].valid && ent[r_idx].complete) begin
            ret_cnt                     = ret_cnt + 2'd1;
            ret_row_n[n].valid          = 1'b1;
            ret_row_n[n].complete       = 1'b1;
            ret_row_n[n].ROBNumber      = r_idx;
            ret_row_n[n].PRegAddrDst    = ent[r_idx].dst;
            ret_row_n[n].OldPRegAddrDst = ent[r_idx].old;
            ret_row_n[n].data           = ent[r_idx].data;
            ret_row_n[n].RegWrite       = ent[r_idx].reg_write;
            ret_row_n[n].MemWrite       = ent[r_idx].mem_write;
            rf_we_n[n]                  = ent[r_idx].reg_write && (ent[r_idx].dst != '0);
            free_v_n[n]                 = ent[r_idx].old != '0;
            store_n[n]                  = ent[r_idx].mem_write;
            ent_n[r_idx].valid          = 1'b0;
            ent_n[r_idx].complete       = 1'b0;
         end else begin
            stop = 1'b1;
         end
      end

      // A lower-numbered FU claims the entry; any later FU hitting the same entry is dropped.
      for (int k = 0; k < 3; k++) begin
         dup   = 1'b0;
         c_idx = i_fu_rob[k];
         for (int j = 0; j < k; j++) begin
            if (i_fu_valid[j] && (i_fu_rob[j] == i_fu_rob[k])) dup = 1'b1;
         end
         if (i_fu_valid[k]) begin
            if (dup || !ent[c_idx].valid || ent[c_idx].complete) begin
               err_n = 1'b1;
            end else begin
               ent_n[c_idx].complete = 1'b1;
               ent_n[c_idx].data     = i_fu_data[k];
            end
         end
      end

      // Capacity uses the registered count: slots retired this cycle reopen next cycle.
      for (int i = 0; i < 2; i++) begin
         if (i_alloc_rows[i].valid) begin
            if ((6'(count) + 6'(acc) + 6'd1) > DEPTH_L) begin
               err_n = 1'b1;
            end else begin
               if (i_alloc_rows[i].ROBNumber != t) err_n = 1'b1;
               ent_n[t].valid     = 1'b1;
               ent_n[t].complete  = 1'b0;
               ent_n[t].dst       = i_alloc_rows[i].PRegAddrDst;
               ent_n[t].old       = i_alloc_rows[i].OldPRegAddrDst;
               ent_n[t].data      = '0;
               ent_n[t].reg_write = i_alloc_rows[i].RegWrite;
               ent_n[t].mem_write = i_alloc_rows[i].MemWrite;
               t                  = t + 4'd1;
               acc                = acc + 2'd1;
            end
         end
      end

      head_n  = head + 4'(ret_cnt);
      tail_n  = t;
      count_n = count + 5'(acc) - 5'(ret_cnt);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int e = 0; e < DEPTH; e++) ent[e] <= '0;
         head    <= '0;
         tail    <= '0;
         count   <= '0;
         o_err   <= 1'b0;
         o_full  <= 1'b0;
         o_empty <= 1'b1;
         for (int n = 0; n < RETIRE_W; n++) begin
            o_retire_rows[n]     <= '0;
            o_rf_we[n]           <= 1'b0;
            o_free_preg_valid[n] <= 1'b0;
            o_store_commit[n]    <= 1'b0;
         end
      end else begin
         for (int e = 0; e < DEPTH; e++) ent[e] <= ent_n[e];
         head    <= head_n;
         tail    <= tail_n;
         count   <= count_n;
         o_err   <= err_n;
         o_full  <= count_n > 5'd14;
         o_empty <= count_n == 5'd0;
         for (int n = 0; n < RETIRE_W; n++) begin
            o_retire_rows[n]     <= ret_row_n[n];
            o_rf_we[n]           <= rf_we_n[n];
            o_free_preg_valid[n] <= free_v_n[n];
            o_store_commit[n]    <= store_n[n];
         end
      end
   end

   // Address/data buses are views of the registered retire rows; idle slots read as zero.
   always_comb begin
      for (int n = 0; n < RETIRE_W; n++) begin
         o_rf_addr[n]   = o_retire_rows[n].PRegAddrDst;
         o_rf_data[n]   = o_retire_rows[n].data;
         o_free_preg[n] = o_retire_rows[n].OldPRegAddrDst;
      end
   end

   assign o_count = count;

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: a queue-based program-order model predicts retirements,
// which a negedge monitor pops and compares against the retire buses and flags.
module tb_reorder_buffer;
   import reorder_buffer_pkg::*;

   logic          i_clk = 1'b0;
   logic          rst;
   rob_row_struct a_rows  [0:1];
   logic          fu_v    [0:2];
   logic [3:0]    fu_r    [0:2];
   word           fu_d    [0:2];
   rob_row_struct r_rows  [0:2];
   logic          rf_we   [0:2];
   p_reg          rf_addr [0:2];
   word           rf_data [0:2];
   logic          free_v  [0:2];
   p_reg          free_p  [0:2];
   logic          st_c    [0:2];
   logic          full, empty, err;
   logic [4:0]    count;

   always #5 i_clk = ~i_clk;

   reorder_buffer dut (
      .i_clk(i_clk), .i_rst(rst), .i_alloc_rows(a_rows),
      .i_fu_valid(fu_v), .i_fu_rob(fu_r), .i_fu_data(fu_d),
      .o_retire_rows(r_rows), .o_rf_we(rf_we), .o_rf_addr(rf_addr), .o_rf_data(rf_data),
      .o_free_preg_valid(free_v), .o_free_preg(free_p), .o_store_commit(st_c),
      .o_full(full), .o_empty(empty), .o_count(count), .o_err(err)
   );

   typedef struct {
      int  slot;
      int  dst;
      int  old;
      bit  rw;
      bit  mw;
      bit  comp;
      word data;
   } mrow_t;

   mrow_t mq[$];
   mrow_t exp_q[$];
   int    m_tail;
   bit    m_err;
   int    n_checks = 0;
   int    n_fail   = 0;
   bit    mon_en   = 1'b0;

   task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic rob_row_struct mk_row(input bit v, input int rob, input int dst,
                                            input int old, input bit rw, input bit mw);
      rob_row_struct r;
      r                = '0;
      r.valid          = v;
      r.ROBNumber      = 4'(rob);
      r.PRegAddrDst    = 6'(dst);
      r.OldPRegAddrDst = 6'(old);
      r.RegWrite       = rw;
      r.MemWrite       = mw;
      return r;
   endfunction

   // Reference: program-order queue; retirement uses the queue as it stood before this edge.
   task automatic model_step();
      int    pre, r, acc, found;
      bit    dup;
      mrow_t nr;
      if (rst) begin
         mq.delete();
         exp_q.delete();
         m_tail = 0;
         m_err  = 1'b0;
         return;
      end
      pre = mq.size();
      r   = 0;
      while (r < 3 && r < pre && mq[r].comp) r++;
      for (int k = 0; k < 3; k++) begin
         if (!fu_v[k]) continue;
         dup = 1'b0;
         for (int j = 0; j < k; j++) if (fu_v[j] && fu_r[j] == fu_r[k]) dup = 1'b1;
         if (dup) begin
            m_err = 1'b1;
            continue;
         end
         found = -1;
         foreach (mq[i]) if (mq[i].slot == int'(fu_r[k])) found = i;
         if (found < 0 || mq[found].comp) m_err = 1'b1;
         else begin
            mq[found].comp = 1'b1;
            mq[found].data = fu_d[k];
         end
      end
      for (int i = 0; i < r; i++) exp_q.push_back(mq.pop_front());
      acc = 0;
      for (int i = 0; i < 2; i++) begin
         if (!a_rows[i].valid) continue;
         if (pre + acc + 1 > 16) begin
            m_err = 1'b1;
            continue;
         end
         if (int'(a_rows[i].ROBNumber) != m_tail) m_err = 1'b1;
         nr.slot = m_tail;
         nr.dst  = int'(a_rows[i].PRegAddrDst);
         nr.old  = int'(a_rows[i].OldPRegAddrDst);
         nr.rw   = a_rows[i].RegWrite;
         nr.mw   = a_rows[i].MemWrite;
         nr.comp = 1'b0;
         nr.data = '0;
         mq.push_back(nr);
         m_tail = (m_tail + 1) % 16;
         acc++;
      end
   endtask

   always @(negedge i_clk) begin
      if (mon_en) begin
         bit    gap;
         mrow_t e;
         gap = 1'b0;
         for (int n = 0; n < 3; n++) begin
            if (r_rows[n].valid) begin
               chk("retire_prefix", gap, 0);
               if (exp_q.size() == 0) begin
                  chk("retire_unexpected", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  chk("ret_rob",      r_rows[n].ROBNumber, e.slot);
                  chk("ret_complete", r_rows[n].complete, 1);
                  chk("ret_dst",      r_rows[n].PRegAddrDst, e.dst);
                  chk("ret_old",      r_rows[n].OldPRegAddrDst, e.old);
                  chk("ret_data",     r_rows[n].data, e.data);
                  chk("ret_rw_mw",    {r_rows[n].RegWrite, r_rows[n].MemWrite}, {e.rw, e.mw});
                  chk("rf_we",        rf_we[n], e.rw && e.dst != 0);
                  chk("rf_addr",      rf_addr[n], e.dst);
                  chk("rf_data",      rf_data[n], e.data);
                  chk("free_valid",   free_v[n], e.old != 0);
                  chk("free_preg",    free_p[n], e.old);
                  chk("store_commit", st_c[n], e.mw);
               end
            end else begin
               gap = 1'b1;
               chk("idle_row", r_rows[n], 0);
               chk("idle_strobes", {rf_we[n], free_v[n], st_c[n]}, 0);
            end
         end
         chk("retire_missing", exp_q.size(), 0);
         chk("count", count, mq.size());
         chk("empty", empty, mq.size() == 0);
         chk("full",  full,  mq.size() > 14);
         chk("err",   err,   m_err);
      end
   end

   task automatic idle();
      rst = 1'b0;
      for (int i = 0; i < 2; i++) a_rows[i] = '0;
      for (int k = 0; k < 3; k++) begin
         fu_v[k] = 1'b0;
         fu_r[k] = '0;
         fu_d[k] = '0;
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      model_step();
      @(negedge i_clk);
      idle();
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      tick();
   endtask

   task automatic fu(input int k, input int rob, input word d);
      fu_v[k] = 1'b1;
      fu_r[k] = 4'(rob);
      fu_d[k] = d;
   endtask

   initial begin
      int idx;
      idle();
      rst = 1'b1;
      tick();
      tick();
      mon_en = 1'b1;
      chk("reset_empty", empty, 1);

      // Single allocate / complete / retire
      a_rows[0] = mk_row(1, 0, 5, 3, 1, 0);
      tick();
      fu(0, 0, 32'h0000_002A);
      tick();
      tick();
      chk("single_data", r_rows[0].data, 32'h2A);
      chk("single_rf_addr", rf_addr[0], 5);
      chk("single_free", free_p[0], 3);

      // Out-of-order completion
      do_reset();
      a_rows[0] = mk_row(1, 0, 10, 11, 1, 0);
      a_rows[1] = mk_row(1, 1, 12, 13, 1, 0);
      tick();
      fu(1, 1, 32'h1111);
      tick();
      tick();
      chk("ooo_no_retire", r_rows[0].valid, 0);
      fu(2, 0, 32'h2222);
      tick();
      tick();
      chk("ooo_order", {r_rows[0].ROBNumber, r_rows[1].ROBNumber}, 8'h01);

      // Triple retire across the wrap point
      do_reset();
      for (int c = 0; c < 7; c++) begin
         a_rows[0] = mk_row(1, 2*c,   2*c+1, 2*c+2, 1, 0);
         a_rows[1] = mk_row(1, 2*c+1, 2*c+2, 2*c+3, 0, 1);
         tick();
      end
      for (int c = 0; c < 5; c++) begin
         for (int k = 0; k < 3; k++) if (3*c + k < 14) fu(k, 3*c + k, $urandom);
         tick();
      end
      repeat (3) tick();
      a_rows[0] = mk_row(1, 14, 20, 21, 1, 0);
      a_rows[1] = mk_row(1, 15, 22, 23, 1, 1);
      tick();
      a_rows[0] = mk_row(1, 0, 24, 0, 1, 0);
      tick();
      fu(0, 15, 32'hF);
      fu(1, 0, 32'h0);
      fu(2, 14, 32'hE);
      tick();
      tick();
      chk("wrap_order", {r_rows[0].ROBNumber, r_rows[1].ROBNumber, r_rows[2].ROBNumber}, 12'hEF0);
      chk("wrap_count", count, 0);

      // Fill to full, then overflow
      do_reset();
      for (int c = 0; c < 8; c++) begin
         a_rows[0] = mk_row(1, 2*c,   1, 1, 1, 0);
         a_rows[1] = mk_row(1, 2*c+1, 2, 2, 1, 0);
         tick();
      end
      chk("fill_full", full, 1);
      a_rows[0] = mk_row(1, 0, 3, 3, 1, 0);
      tick();
      chk("overflow_count", count, 16);
      chk("overflow_err", err, 1);

      // Store to r0, then a completion to an empty slot
      do_reset();
      a_rows[0] = mk_row(1, 0, 0, 7, 1, 1);
      tick();
      fu(0, 0, 32'hCAFE);
      tick();
      tick();
      chk("store_rf_we", rf_we[0], 0);
      chk("store_commit", st_c[0], 1);
      fu(1, 9, 32'h9);
      tick();
      chk("bad_fu_err", err, 1);

      // Reset with six rows occupied
      do_reset();
      for (int c = 0; c < 3; c++) begin
         a_rows[0] = mk_row(1, 2*c,   4, 5, 1, 0);
         a_rows[1] = mk_row(1, 2*c+1, 6, 7, 1, 0);
         tick();
      end
      rst = 1'b1;
      tick();
      chk("midrst_empty", empty, 1);
      a_rows[0] = mk_row(1, 0, 8, 9, 1, 0);
      tick();
      chk("midrst_realloc_err", err, 0);

      // Randomized traffic with occasional protocol errors and resets
      do_reset();
      for (int c = 0; c < 2000; c++) begin
         if ($urandom_range(299) == 0) rst = 1'b1;
         for (int i = 0; i < 2; i++) begin
            if ($urandom_range(1) == 1) begin
               idx = (m_tail + (i == 1 && a_rows[0].valid ? 1 : 0)) % 16;
               if ($urandom_range(31) == 0) idx = $urandom_range(15);
               a_rows[i] = mk_row(1, idx, $urandom_range(63), $urandom_range(63),
                                  1'($urandom_range(1)), 1'($urandom_range(1)));
            end
         end
         for (int k = 0; k < 3; k++) begin
            if ($urandom_range(1) == 1) begin
               if (mq.size() > 0 && $urandom_range(7) != 0)
                  idx = mq[$urandom_range(mq.size() - 1)].slot;
               else
                  idx = $urandom_range(15);
               fu(k, idx, $urandom);
            end
         end
         tick();
      end
      repeat (4) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
